// File: rtl/seq_counter_param.sv
// Up/down counter with enable prescaler, wrap or saturate at limits, sticky overflow and pad oeb.
// Optional parallel load is built only when SEQ_COUNTER_LOAD_EN is defined.
module seq_counter_param #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic [WIDTH+1:0] oeb
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [PW-1:0] pre_cnt;
    logic          at_limit_c;
    logic          step_c;

    // Limit in the currently requested direction; also drives terminal count.
    assign at_limit_c = up ? (count == ALL_ONES) : (count == '0);
    assign tc         = at_limit_c;
    assign step_c     = (pre_cnt == PRE_LAST);
    assign oeb        = {(WIDTH + 2){rst}};

`ifdef SEQ_COUNTER_LOAD_EN
`else
    logic unused_load;
    assign unused_load = ^{load, load_val};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            pre_cnt <= '0;
            ovf     <= 1'b0;
        end
`ifdef SEQ_COUNTER_LOAD_EN
        else if (load) begin
            count   <= load_val;
            pre_cnt <= '0;
            ovf     <= 1'b0;
        end
`endif
        else if (en) begin
            if (step_c) begin
                pre_cnt <= '0;
                if (at_limit_c) begin
                    ovf <= 1'b1;
                    if (!SATURATE) begin
                        count <= up ? '0 : ALL_ONES;
                    end
                end else begin
                    count <= up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
                end
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_counter_param.sv
// Scoreboard bench for seq_counter_param: wrap, saturate and prescale-by-4 instances on shared stimulus.
module tb_seq_counter_param;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;

    logic [15:0] c0, c1, c2;
    logic        tc0, tc1, tc2, ovf0, ovf1, ovf2;
    logic [17:0] oeb0, oeb1, oeb2;

    int unsigned cyc_n  = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int unsigned stamp;
        int unsigned dut;
        string       name;
        logic [15:0] count;
        logic        tc;
        logic        ovf;
        logic [17:0] oeb;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    seq_counter_param #(.WIDTH(16), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(c0), .tc(tc0), .ovf(ovf0), .oeb(oeb0)
    );

    seq_counter_param #(.WIDTH(16), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(c1), .tc(tc1), .ovf(ovf1), .oeb(oeb1)
    );

    seq_counter_param #(.WIDTH(16), .PRESCALE(4), .SATURATE(1'b0)) u_pre (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(c2), .tc(tc2), .ovf(ovf2), .oeb(oeb2)
    );

    // Monitor: one sample just after every rising edge, popping entries due at this edge.
    always @(posedge clk) begin
        exp_t        e;
        logic [34:0] act;
        logic [34:0] req;
        #1;
        cyc_n++;
        while (q.size() > 0 && q[0].stamp <= cyc_n) begin
            e = q.pop_front();
            case (e.dut)
                0:       act = {c0, tc0, ovf0, oeb0};
                1:       act = {c1, tc1, ovf1, oeb1};
                default: act = {c2, tc2, ovf2, oeb2};
            endcase
            req = {e.count, e.tc, e.ovf, e.oeb};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s dut%0d edge %0d: count=%h tc=%b ovf=%b oeb=%h, required count=%h tc=%b ovf=%b oeb=%h",
                         e.name, e.dut, cyc_n, act[34:19], act[18], act[17], act[16:0] == 17'h0 ? {1'b0, act[16:0]} : act[17:0],
                         e.count, e.tc, e.ovf, e.oeb);
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [15:0] lv);
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
    endtask

    task automatic push(input int unsigned dut, input string name, input logic [15:0] xc,
                        input logic xtc, input logic xovf);
        exp_t e;
        e.stamp = cyc_n + 1;
        e.dut   = dut;
        e.name  = name;
        e.count = xc;
        e.tc    = xtc;
        e.ovf   = xovf;
        e.oeb   = {18{rst}};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input int unsigned dut, input string name, input logic r, input logic e,
                        input logic u, input logic l, input logic [15:0] lv,
                        input logic [15:0] xc, input logic xtc, input logic xovf);
        drive(r, e, u, l, lv);
        push(dut, name, xc, xtc, xovf);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

        // Reset held with enable high, then a 100-edge up-count.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
            push(1, "rst_sat", 16'h0000, 1'b0, 1'b0);
            push(2, "rst_pre", 16'h0000, 1'b0, 1'b0);
            step(0, "rst_wrap", 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0);
        end
        for (int i = 0; i < 100; i++)
            step(0, "count_up", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'(i + 1), 1'b0, 1'b0);
        step(0, "hold_a", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'd100, 1'b0, 1'b0);
        step(0, "hold_b", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'd100, 1'b0, 1'b0);

        // Wrap in both directions and tc at each limit.
        step(0, "rst_w", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0);
        step(0, "down_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'hFFFF, 1'b0, 1'b1);
        step(0, "tc_up_max", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'hFFFF, 1'b1, 1'b1);
        step(0, "up_wrap", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b1);
        step(0, "tc_dn_zero", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b1);
        step(0, "rst_clr_ovf", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);
`ifdef SEQ_COUNTER_LOAD_EN
        step(0, "load_fffe", 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0);
        step(0, "wrap_ffff", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'hFFFF, 1'b1, 1'b0);
        step(0, "wrap_0000", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b1);
        step(0, "wrap_0001", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0001, 1'b0, 1'b1);
`endif

        // Saturation at zero (and at all-ones when loadable).
        step(1, "sat_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);
`ifdef SEQ_COUNTER_LOAD_EN
        step(1, "sat_load1", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        step(1, "sat_dn_to0", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);
`endif
        for (int i = 0; i < 3; i++)
            step(1, "sat_hold0", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b1);
`ifdef SEQ_COUNTER_LOAD_EN
        step(1, "sat_load_max", 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        step(1, "sat_hold_max", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'hFFFF, 1'b1, 1'b1);
`endif

        // Prescale by 4, enable gap mid-prescale, direction change mid-prescale.
        step(2, "pre_rst", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(2, "pre4", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'((i + 1) / 4), 1'b0, 1'b0);
        step(2, "pre4_mid", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'd2, 1'b0, 1'b0);
        step(2, "pre4_gap", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'd2, 1'b0, 1'b0);
        step(2, "pre4_gap", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'd2, 1'b0, 1'b0);
        step(2, "pre4_res", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'd2, 1'b0, 1'b0);
        step(2, "pre4_res", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'd2, 1'b0, 1'b0);
        step(2, "pre4_step3", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'd3, 1'b0, 1'b0);
        step(2, "dir_a", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'd3, 1'b0, 1'b0);
        step(2, "dir_b", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'd3, 1'b0, 1'b0);
        step(2, "dir_c", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'd3, 1'b0, 1'b0);
        step(2, "dir_down", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'd2, 1'b0, 1'b0);

        // Reset together with load mid-prescale: reset wins, full prescale afterwards.
        step(2, "pre_rst2", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++)
            step(2, "to5", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'((i + 1) / 4), 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        push(0, "rst_load_w", 16'h0000, 1'b0, 1'b0);
        step(2, "rst_load", 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(2, "after_rst", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'((i + 1) / 4), 1'b0, 1'b0);

        // Load pulse while counting.
        step(0, "rst6", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(0, "pre_load", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'(i + 1), 1'b0, 1'b0);
`ifdef SEQ_COUNTER_LOAD_EN
        step(0, "load_pulse", 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0);
        step(0, "post_load", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h1235, 1'b0, 1'b0);
        step(0, "load_no_en", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 16'h0042, 1'b0, 1'b0);
`else
        step(0, "load_ignored", 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0004, 1'b0, 1'b0);
        step(0, "post_load", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0005, 1'b0, 1'b0);
        step(0, "load_no_en", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 16'h0005, 1'b0, 1'b0);
`endif

        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        repeat (3) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
